branch_pred_btb: RTL

- Parametrised branch target buffer plus 2-bit bimodal predictor for the 5-stage MIPS pipeline.
- IF looks up the current PC in the same cycle and gets a predicted taken/target for NPC selection.
- The stage that resolves branches (EX/MEM) writes back the real outcome.
- Replaces the fixed "predict not-taken, redirect at resolve" scheme. Adds allocation, flush and mispredict statistics.

---
 rtl/mips_bp_pkg.sv | 27 ++
 rtl/branch_pred_btb_sat_stat_counter.sv | 19 +
 rtl/branch_pred_btb.sv | 103 ++++++++++
 3 files changed

// File: rtl/mips_bp_pkg.sv
// Shared encodings and helpers for the MIPS branch predictor.
// Counter states use the classic bimodal SNT/WNT/WT/ST ordering.
package mips_bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_cnt_e;

    localparam bp_cnt_e ALLOC_CNT = WT;

    function automatic bp_cnt_e sat_update(input bp_cnt_e cnt, input logic taken);
        bp_cnt_e nxt;
        nxt = cnt;
        case (cnt)
            SNT: nxt = taken ? WNT : SNT;
            WNT: nxt = taken ? WT  : SNT;
            WT:  nxt = taken ? ST  : WNT;
            ST:  nxt = taken ? ST  : WT;
            default: nxt = cnt;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/branch_pred_btb_sat_stat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_stat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/branch_pred_btb.sv
// Direct-mapped BTB with 2-bit bimodal counters: zero-latency lookup for IF,
// registered update from the resolving stage, plus mispredict statistics.
module branch_pred_btb
    import mips_bp_pkg::*;
#(
    parameter  int ENTRIES = 64,
    parameter  int TAG_W   = 8,
    parameter  int ADDR_W  = 32,
    parameter  int STAT_W  = 32,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] lkp_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_pred_taken,
    input  logic [ADDR_W-1:0] upd_pred_target,
    input  logic              flush,
    output logic              mispredict,
    output logic [STAT_W-1:0] stat_updates,
    output logic [STAT_W-1:0] stat_mispred
);

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    bp_cnt_e            cnt_q [ENTRIES];
    logic [ADDR_W-1:0]  tgt_q [ENTRIES];

    logic [IDX_W-1:0] lkp_idx;
    logic [TAG_W-1:0] lkp_tag;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    logic             upd_write;

    assign lkp_idx = lkp_pc[IDX_W+1:2];
    assign lkp_tag = lkp_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{lkp_pc[1:0], lkp_pc[ADDR_W-1:IDX_W+TAG_W+2],
                              upd_pc[1:0], upd_pc[ADDR_W-1:IDX_W+TAG_W+2]};

    // Valid gates every read so uninitialised tag/counter/target never leak out.
    assign pred_hit    = valid_q[lkp_idx] && (tag_q[lkp_idx] == lkp_tag);
    assign pred_taken  = pred_hit && cnt_q[lkp_idx][1];
    assign pred_target = pred_hit ? tgt_q[lkp_idx] : '0;

    assign mispredict = upd_valid &&
                        ((upd_pred_taken != upd_taken) ||
                         (upd_taken && (upd_pred_target != upd_target)));

    assign upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign upd_write = upd_valid && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else if (upd_valid && !upd_hit && upd_taken) begin
            valid_q[upd_idx] <= 1'b1;
        end
    end

    // Payload arrays carry no reset; they are only observed under valid.
    always_ff @(posedge clk) begin
        if (upd_write) begin
            if (upd_hit) begin
                cnt_q[upd_idx] <= sat_update(cnt_q[upd_idx], upd_taken);
                if (upd_taken) begin
                    tgt_q[upd_idx] <= upd_target;
                end
            end else if (upd_taken) begin
                tag_q[upd_idx] <= upd_tag;
                cnt_q[upd_idx] <= ALLOC_CNT;
                tgt_q[upd_idx] <= upd_target;
            end
        end
    end

    sat_stat_counter #(.W(STAT_W)) u_stat_updates (
        .clk (clk),
        .rst (rst),
        .inc (upd_valid),
        .cnt (stat_updates)
    );

    sat_stat_counter #(.W(STAT_W)) u_stat_mispred (
        .clk (clk),
        .rst (rst),
        .inc (mispredict),
        .cnt (stat_mispred)
    );

endmodule
